apb_req_scheduler: RTL and testbench

- Upstream command stage for the APB master/slave subsystem. It drives the subsystem's add_i and external_wdata_i inputs and consumes its ready_o and rdata_o outputs.
- Buffers host read/write requests in a DEPTH-entry FIFO and issues them one at a time, holding each opcode until the slave signals ready.
- Returns one response per request (captured read data, optional error flag) over a valid/ready interface.

---
 rtl/apb_req_scheduler.sv | 160 ++++++++++++++++
 tb/tb_apb_req_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_scheduler.sv
// apb_req_scheduler: buffers host read/write requests in a FIFO and issues them one at a
// time to the APB subsystem, returning one response each. Optional macro: APB_SCHED_TIMEOUT_EN.
module apb_req_scheduler #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [DATA_W-1:0]          req_wdata_i,
  output logic [1:0]                 add_o,
  output logic [DATA_W-1:0]          wdata_o,
  input  logic                       ready_i,
  input  logic [DATA_W-1:0]          rdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_write_o,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
  output logic                       busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] ADD_NOP   = 2'b00;
  localparam logic [1:0] ADD_READ  = 2'b01;
  localparam logic [1:0] ADD_WRITE = 2'b11;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("apb_req_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic              write;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_GAP
  } state_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic          cmd_write;
  logic          push;
  logic          pop;

`ifdef APB_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wait_cnt;
`endif

  // Acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
  assign req_ready_o  = (count < CW'(DEPTH));
  assign push         = req_valid_i && req_ready_o;
  assign pop          = (state == S_IDLE) && (count != '0) && !rsp_valid_o;
  assign head         = mem[rd_ptr];
  assign fifo_count_o = count;
  assign busy_o       = (state != S_IDLE) || (count != '0) || rsp_valid_o;

  always_ff @(posedge pclk) begin
    if (push) begin
      mem[wr_ptr] <= '{write: req_write_i, data: req_wdata_i};
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= S_IDLE;
      cmd_write   <= 1'b0;
      add_o       <= ADD_NOP;
      wdata_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
`ifdef APB_SCHED_TIMEOUT_EN
      rsp_err_o   <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      // A response is only loaded while none is pending, so clear and load never collide.
      if (rsp_valid_o && rsp_ready_i) rsp_valid_o <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (pop) begin
            cmd_write <= head.write;
            add_o     <= head.write ? ADD_WRITE : ADD_READ;
            wdata_o   <= head.write ? head.data : '0;
`ifdef APB_SCHED_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (ready_i) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= cmd_write;
            rsp_rdata_o <= cmd_write ? '0 : rdata_i;
`ifdef APB_SCHED_TIMEOUT_EN
            rsp_err_o   <= 1'b0;
`endif
            add_o       <= ADD_NOP;
            wdata_o     <= '0;
            state       <= S_GAP;
          end
`ifdef APB_SCHED_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            rsp_valid_o <= 1'b1;
            rsp_write_o <= cmd_write;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            add_o       <= ADD_NOP;
            wdata_o     <= '0;
            state       <= S_GAP;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
`endif
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef APB_SCHED_TIMEOUT_EN
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_req_scheduler.sv
// tb_apb_req_scheduler: directed table, hand-written corner sequences and randomized traffic
// for apb_req_scheduler, all checked against a queue-based request/response model.
`timescale 1ns/1ps
module tb_apb_req_scheduler;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(DEPTH + 1);

  logic              pclk = 1'b0;
  logic              preset;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [1:0]        add_o;
  logic [DATA_W-1:0] wdata_o;
  logic              ready_i;
  logic [DATA_W-1:0] rdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic              rsp_write_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic [CW-1:0]     fifo_count_o;
  logic              busy_o;

  apb_req_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .pclk         (pclk),
    .preset       (preset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_wdata_i  (req_wdata_i),
    .add_o        (add_o),
    .wdata_o      (wdata_o),
    .ready_i      (ready_i),
    .rdata_i      (rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_write_o  (rsp_write_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .fifo_count_o (fifo_count_o),
    .busy_o       (busy_o)
  );

  always #5 pclk = ~pclk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a queue of pending requests, the one command on the bus, and the
  // response slot. Updated once per rising edge from the inputs seen before that edge.
  typedef struct {
    bit                w;
    logic [DATA_W-1:0] d;
  } mreq_t;

  mreq_t             mq[$];
  mreq_t             m_cmd;
  bit                m_active;
  bit                m_in_gap;
  int                m_waits;
  bit                m_rsp_valid;
  bit                m_rsp_w;
  logic [DATA_W-1:0] m_rsp_d;
  bit                m_rsp_err;

  function automatic void model_reset();
    mq.delete();
    m_active    = 0;
    m_in_gap    = 0;
    m_waits     = 0;
    m_rsp_valid = 0;
    m_rsp_w     = 0;
    m_rsp_d     = '0;
    m_rsp_err   = 0;
  endfunction

  function automatic void m_finish(input bit err);
    m_active    = 0;
    m_in_gap    = 1;
    m_rsp_valid = 1;
    m_rsp_w     = m_cmd.w;
    m_rsp_d     = (m_cmd.w || err) ? '0 : rdata_i;
    m_rsp_err   = err;
  endfunction

  function automatic void model_step();
    bit    had_rsp = m_rsp_valid;
    bit    accept  = req_valid_i && (mq.size() < DEPTH);
    mreq_t nr;
    if (m_rsp_valid && rsp_ready_i) m_rsp_valid = 0;
    if (m_in_gap) begin
      m_in_gap = 0;
    end else if (m_active) begin
      if (ready_i) m_finish(0);
`ifdef APB_SCHED_TIMEOUT_EN
      else begin
        m_waits++;
        if (m_waits == TIMEOUT) m_finish(1);
      end
`endif
    end else if (mq.size() > 0 && !had_rsp) begin
      m_cmd    = mq.pop_front();
      m_active = 1;
      m_waits  = 0;
    end
    if (accept) begin
      nr.w = req_write_i;
      nr.d = req_wdata_i;
      mq.push_back(nr);
    end
  endfunction

  function automatic void check_all();
    logic [1:0]        e_add;
    logic [DATA_W-1:0] e_wd;
    e_add = m_active ? (m_cmd.w ? 2'b11 : 2'b01) : 2'b00;
    e_wd  = (m_active && m_cmd.w) ? m_cmd.d : '0;
    chk("add", add_o, e_add);
    chk("wdata", wdata_o, e_wd);
    chk("req_ready", req_ready_o, mq.size() < DEPTH);
    chk("count", fifo_count_o, mq.size());
    chk("rsp_valid", rsp_valid_o, m_rsp_valid);
    chk("busy", busy_o, m_active || m_in_gap || mq.size() != 0 || m_rsp_valid);
    if (m_rsp_valid) begin
      chk("rsp_write", rsp_write_o, m_rsp_w);
      chk("rsp_rdata", rsp_rdata_o, m_rsp_d);
      chk("rsp_err", rsp_err_o, m_rsp_err);
    end
  endfunction

  task automatic cycle();
    @(posedge pclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    req_valid_i = 0;
    req_write_i = 0;
    req_wdata_i = '0;
    ready_i     = 0;
    rdata_i     = '0;
    rsp_ready_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    preset = 1;
    model_reset();
    #2;
    preset = 0;
  endtask

  typedef struct {
    logic              rv;
    logic              rw;
    logic [DATA_W-1:0] rd;
    logic              rdy;
    logic [DATA_W-1:0] rdat;
    logic              rr;
    logic [1:0]        e_add;
    logic [DATA_W-1:0] e_wdata;
    logic [CW-1:0]     e_cnt;
    logic              e_rv;
    logic              e_rw;
    logic [DATA_W-1:0] e_rdata;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    // write 0xDEADBEEF held 3 cycles, one NOP, then a read of 0x12345678, then ready_i while idle
    tbl[0]  = '{1, 1, 32'hDEADBEEF, 0, 32'h0,        0, 2'b00, 32'h0,        1, 0, 0, 32'h0};
    tbl[1]  = '{0, 0, 32'h0,        0, 32'h0,        0, 2'b11, 32'hDEADBEEF, 0, 0, 0, 32'h0};
    tbl[2]  = '{0, 0, 32'h0,        0, 32'h0,        0, 2'b11, 32'hDEADBEEF, 0, 0, 0, 32'h0};
    tbl[3]  = '{0, 0, 32'h0,        0, 32'h0,        0, 2'b11, 32'hDEADBEEF, 0, 0, 0, 32'h0};
    tbl[4]  = '{0, 0, 32'h0,        1, 32'hA5A5A5A5, 0, 2'b00, 32'h0,        0, 1, 1, 32'h0};
    tbl[5]  = '{0, 0, 32'h0,        0, 32'h0,        1, 2'b00, 32'h0,        0, 0, 0, 32'h0};
    tbl[6]  = '{1, 0, 32'h0BADF00D, 0, 32'h0,        1, 2'b00, 32'h0,        1, 0, 0, 32'h0};
    tbl[7]  = '{0, 0, 32'h0,        0, 32'h12345678, 0, 2'b01, 32'h0,        0, 0, 0, 32'h0};
    tbl[8]  = '{0, 0, 32'h0,        0, 32'h12345678, 0, 2'b01, 32'h0,        0, 0, 0, 32'h0};
    tbl[9]  = '{0, 0, 32'h0,        1, 32'h12345678, 0, 2'b00, 32'h0,        0, 1, 0, 32'h12345678};
    tbl[10] = '{0, 0, 32'h0,        0, 32'h0,        1, 2'b00, 32'h0,        0, 0, 0, 32'h0};
    tbl[11] = '{0, 0, 32'h0,        1, 32'hFFFFFFFF, 1, 2'b00, 32'h0,        0, 0, 0, 32'h0};

    idle_inputs();
    preset = 1;
    model_reset();
    #2;
    chk("rst_add", add_o, 2'b00);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_write", rsp_write_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    #6;
    preset = 0;
    cycle();

    for (int i = 0; i < 12; i++) begin
      req_valid_i = tbl[i].rv;
      req_write_i = tbl[i].rw;
      req_wdata_i = tbl[i].rd;
      ready_i     = tbl[i].rdy;
      rdata_i     = tbl[i].rdat;
      rsp_ready_i = tbl[i].rr;
      cycle();
      chk($sformatf("tbl%0d_add", i), add_o, tbl[i].e_add);
      chk($sformatf("tbl%0d_wdata", i), wdata_o, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_count", i), fifo_count_o, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid_o, tbl[i].e_rv);
      if (tbl[i].e_rv) begin
        chk($sformatf("tbl%0d_rsp_write", i), rsp_write_o, tbl[i].e_rw);
        chk($sformatf("tbl%0d_rsp_rdata", i), rsp_rdata_o, tbl[i].e_rdata);
        chk($sformatf("tbl%0d_rsp_err", i), rsp_err_o, 0);
      end
    end

    // asynchronous reset while a write is on the bus
    do_reset();
    req_valid_i = 1; req_write_i = 1; req_wdata_i = 32'hCAFEF00D;
    cycle();
    cycle();
    req_valid_i = 0;
    chk("pre_reset_add", add_o, 2'b11);
    preset = 1;
    #1;
    chk("async_rst_add", add_o, 2'b00);
    chk("async_rst_count", fifo_count_o, 0);
    chk("async_rst_rsp_valid", rsp_valid_o, 0);
    chk("async_rst_busy", busy_o, 0);
    model_reset();
    #2;
    preset = 0;

    // back-pressure: fill the FIFO behind a pending response
    do_reset();
    ready_i = 1; rsp_ready_i = 0; req_valid_i = 1;
    for (int i = 0; i < 8; i++) begin
      req_write_i = i[0];
      req_wdata_i = 32'h1000 + i;
      rdata_i     = 32'h2000 + i;
      cycle();
    end
    chk("full_count", fifo_count_o, DEPTH);
    chk("full_req_ready", req_ready_o, 0);
    chk("full_rsp_valid", rsp_valid_o, 1);
    rsp_ready_i = 1;
    cycle();
    chk("full_push_refused", fifo_count_o, DEPTH);
    req_valid_i = 0; rsp_ready_i = 0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_no_issue", add_o, 2'b00);
    end
    rsp_ready_i = 1;
    cycle();
    rsp_ready_i = 0;
    chk("ack_clears_rsp", rsp_valid_o, 0);
    cycle();
    chk("issue_after_ack", add_o != 2'b00, 1);
    rsp_ready_i = 1;
    for (int i = 0; i < 24; i++) cycle();
    chk("drained", busy_o, 0);

    // simultaneous push and pop at count 2
    do_reset();
    ready_i = 1; req_valid_i = 1; req_wdata_i = 32'h55;
    for (int i = 0; i < 3; i++) cycle();
    req_valid_i = 0;
    cycle();
    cycle();
    rsp_ready_i = 1;
    cycle();
    rsp_ready_i = 0;
    chk("pushpop_pre_count", fifo_count_o, 2);
    req_valid_i = 1;
    cycle();
    req_valid_i = 0;
    chk("pushpop_count", fifo_count_o, 2);
    chk("pushpop_issue", add_o != 2'b00, 1);

`ifdef APB_SCHED_TIMEOUT_EN
    do_reset();
    rsp_ready_i = 1; ready_i = 0;
    req_valid_i = 1; req_write_i = 0;
    cycle();
    req_write_i = 1; req_wdata_i = 32'h77;
    cycle();
    req_valid_i = 0;
    n = (add_o == 2'b01) ? 1 : 0;
    seen = 0;
    for (int i = 0; i < 4 * TIMEOUT; i++) begin
      cycle();
      if (add_o == 2'b01) n++;
      else if (n > 0) begin
        seen = 1;
        break;
      end
    end
    chk("timeout_seen", seen, 1);
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_rsp_valid", rsp_valid_o, 1);
    chk("timeout_err", rsp_err_o, 1);
    chk("timeout_rdata", rsp_rdata_o, 0);
    ready_i = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (add_o == 2'b11) begin
        seen = 1;
        break;
      end
    end
    chk("after_timeout_issue", seen, 1);
`endif

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req_valid_i = ($urandom_range(0, 99) < 50);
      req_write_i = $urandom_range(0, 1);
      req_wdata_i = $urandom;
      ready_i     = ($urandom_range(0, 99) < 35);
      rdata_i     = $urandom;
      rsp_ready_i = ($urandom_range(0, 99) < 60);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
